// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings,
// port identifiers and the default memory size.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CPU      = 1'b0;
  localparam logic PORT_DMA      = 1'b1;
  localparam int   MEM_BYTES_DEF = 128;

  // One-hot pulse vector {port1, port0} for a given port ID.
  function automatic logic [1:0] port_onehot(input logic id);
    return (id == PORT_DMA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker: on a tie the priority holder wins,
// otherwise the single requester wins.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic prio,
  output logic winner,
  output logic any
);

  assign any    = req0 | req1;
  assign winner = (req0 & req1) ? prio : (req1 ? PORT_DMA : PORT_CPU);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 128-byte data memory.
// Optional alignment check enabled by defining DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              gnt0_o,
  output logic              gnt1_o,
  output logic              done0_o,
  output logic              done1_o,
  output logic              err0_o,
  output logic              err1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - 4);

  state_t            r_state;
  logic              r_prio;
  logic              r_win;
  logic              r_we;
  logic              r_err;
  logic [1:0]        r_gnt;
  logic [1:0]        r_done;
  logic [1:0]        r_err_out;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_read;
  logic              r_mem_write;

  logic              w_winner;
  logic              w_any;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_range_err;
  logic              w_addr_err;
  logic [DATA_W-1:0] w_rdata_capture;

  rr_arb2 u_rr_arb2 (
    .req0   (req0_i),
    .req1   (req1_i),
    .prio   (r_prio),
    .winner (w_winner),
    .any    (w_any)
  );

  assign w_sel_we    = w_winner ? we1_i    : we0_i;
  assign w_sel_addr  = w_winner ? addr1_i  : addr0_i;
  assign w_sel_wdata = w_winner ? wdata1_i : wdata0_i;
  assign w_range_err = w_sel_addr > LAST_WORD;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign w_addr_err = w_range_err | (w_sel_addr[1:0] != 2'b00);
`else
  assign w_addr_err = w_range_err;
`endif

  // A rejected access reports zero data rather than whatever the bus shows.
  assign w_rdata_capture = r_err ? '0 : mem_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_prio      <= PORT_CPU;
      r_win       <= PORT_CPU;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_gnt       <= 2'b00;
      r_done      <= 2'b00;
      r_err_out   <= 2'b00;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state     <= S_ACCESS;
            r_win       <= w_winner;
            r_we        <= w_sel_we;
            r_err       <= w_addr_err;
            r_gnt       <= port_onehot(w_winner);
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_read  <= ~w_sel_we & ~w_addr_err;
            r_mem_write <= w_sel_we & ~w_addr_err;
          end
        end
        S_ACCESS: begin
          r_state     <= S_RESP;
          r_gnt       <= 2'b00;
          r_mem_addr  <= '0;
          r_mem_wdata <= '0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_done      <= port_onehot(r_win);
          r_err_out   <= r_err ? port_onehot(r_win) : 2'b00;
          // Successful writes leave the port's read data untouched.
          if (r_err || !r_we) begin
            if (r_win == PORT_DMA) begin
              r_rdata1 <= w_rdata_capture;
            end else begin
              r_rdata0 <= w_rdata_capture;
            end
          end
        end
        S_RESP: begin
          r_state   <= S_IDLE;
          r_done    <= 2'b00;
          r_err_out <= 2'b00;
          r_prio    <= ~r_prio;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0_o      = r_gnt[0];
  assign gnt1_o      = r_gnt[1];
  assign done0_o     = r_done[0];
  assign done1_o     = r_done[1];
  assign err0_o      = r_err_out[0];
  assign err1_o      = r_err_out[1];
  assign rdata0_o    = r_rdata0;
  assign rdata1_o    = r_rdata1;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign mem_read_o  = r_mem_read;
  // Reset on the closing edge of ACCESS must not let a write land.
  assign mem_write_o = r_mem_write & ~rst_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed accesses with a response
// scoreboard drained by a done-driven monitor, plus a byte-array memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  logic [7:0]  mem [128];
  logic        mem_load = 1'b1;
  logic [6:0]  ma;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] hold0 = '0, hold1 = '0;

  dmem_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_i      (req0),
    .req1_i      (req1),
    .we0_i       (we0),
    .we1_i       (we1),
    .addr0_i     (addr0),
    .addr1_i     (addr1),
    .wdata0_i    (wdata0),
    .wdata1_i    (wdata1),
    .gnt0_o      (gnt0),
    .gnt1_o      (gnt1),
    .done0_o     (done0),
    .done1_o     (done1),
    .err0_o      (err0),
    .err1_o      (err1),
    .rdata0_o    (rdata0),
    .rdata1_o    (rdata1),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory; each byte preloaded with its own address.
  assign ma        = mem_addr[6:0];
  assign mem_rdata = {mem[ma + 7'd3], mem[ma + 7'd2], mem[ma + 7'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'(i);
    end else if (mem_write) begin
      mem[ma]        <= mem_wdata[7:0];
      mem[ma + 7'd1] <= mem_wdata[15:8];
      mem[ma + 7'd2] <= mem_wdata[23:16];
      mem[ma + 7'd3] <= mem_wdata[31:24];
    end
  end

  function automatic logic [31:0] mem_word(input logic [6:0] a);
    return {mem[a + 7'd3], mem[a + 7'd2], mem[a + 7'd1], mem[a]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected response: successful writes return the port's held read data.
  task automatic push_exp(input logic port, input logic we, input logic err,
                          input logic [31:0] rdata);
    exp_t e;
    e.port = port;
    e.err  = err;
    if (err)     e.rdata = '0;
    else if (we) e.rdata = port ? hold1 : hold0;
    else         e.rdata = rdata;
    if (port) hold1 = e.rdata; else hold0 = e.rdata;
    sb.push_back(e);
  endtask

  task automatic drive(input logic port, input logic r, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    if (port) begin
      req1 = r; we1 = we; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; we0 = we; addr0 = a; wdata0 = d;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done0 || done1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {62'd0, done1, done0}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_port", {62'd0, done1, done0}, e.port ? 64'd2 : 64'd1);
        check("done_err", 64'(e.port ? err1 : err0), 64'(e.err));
        check("done_rdata", 64'(e.port ? rdata1 : rdata0), 64'(e.rdata));
        $display("txn port %0d err %0d rdata %08h", e.port, e.port ? err1 : err0,
                 e.port ? rdata1 : rdata0);
      end
    end
  end

  // Single access from IDLE: gnt one cycle later, done the cycle after, then idle.
  task automatic do_access(input logic port, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic err,
                           input logic [31:0] rdata, input string name);
    push_exp(port, we, err, rdata);
    drive(port, 1'b1, we, a, d);
    @(posedge clk); #1;
    check({name, "_gnt"}, {62'd0, gnt1, gnt0}, port ? 64'd2 : 64'd1);
    check({name, "_strobe"}, {62'd0, mem_read, mem_write}, {62'd0, ~we & ~err, we & ~err});
    if (!err) check({name, "_addr"}, 64'(mem_addr), 64'(a));
    drive(port, 1'b0, we, a, d);
    @(posedge clk); #1;
    check({name, "_done"}, {62'd0, done1, done0}, port ? 64'd2 : 64'd1);
    @(posedge clk); #1;
  endtask

  // Simultaneous requests: the first winner is granted at +1, the other at +4.
  task automatic both_req(input logic first,
                          input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                          input logic [31:0] r0,
                          input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                          input logic [31:0] r1, input string name);
    int g0 = 0;
    int g1 = 0;
    if (first) begin
      push_exp(1'b1, w1, 1'b0, r1);
      push_exp(1'b0, w0, 1'b0, r0);
    end else begin
      push_exp(1'b0, w0, 1'b0, r0);
      push_exp(1'b1, w1, 1'b0, r1);
    end
    drive(1'b0, 1'b1, w0, a0, d0);
    drive(1'b1, 1'b1, w1, a1, d1);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (gnt0) begin g0 = k; req0 = 1'b0; end
      if (gnt1) begin g1 = k; req1 = 1'b0; end
    end
    check({name, "_gnt0_cycle"}, 64'(g0), first ? 64'd4 : 64'd1);
    check({name, "_gnt1_cycle"}, 64'(g1), first ? 64'd1 : 64'd4);
  endtask

  initial begin
    logic [8:0] dvec;
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {56'd0, gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write}, 64'd0);
    check("reset_rdata", {rdata1, rdata0}, 64'd0);
    check("reset_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    mem_load = 1'b0;
    rst      = 1'b0;

    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "p0_wr");
    check("mem_0x10", 64'(mem_word(7'h10)), 64'hDEADBEEF);
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "p0_rd");

    both_req(1'b0, 1'b1, 32'h20, 32'h11223344, 32'h0,
                   1'b0, 32'h7C, 32'h0, 32'h7F7E7D7C, "both1");
    both_req(1'b0, 1'b0, 32'h20, 32'h0, 32'h11223344,
                   1'b0, 32'h00, 32'h0, 32'h03020100, "both2");

    do_access(1'b1, 1'b0, 32'h7D, 32'h0, 1'b1, 32'h0, "p1_range");

    // Port 0 holds its request: completions land 3 cycles apart.
    push_exp(1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    push_exp(1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    push_exp(1'b0, 1'b0, 1'b0, 32'hDEADBEEF);
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    dvec = '0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      dvec[k-1] = done0;
      if (k == 8) req0 = 1'b0;
    end
    check("cont_done_pattern", 64'(dvec), 64'h092);

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    do_access(1'b0, 1'b0, 32'h06, 32'h0, 1'b1, 32'h0, "p0_unaligned");
`else
    do_access(1'b0, 1'b0, 32'h06, 32'h0, 1'b0, 32'h09080706, "p0_unaligned");
`endif

    // Reset lands on the closing edge of a port-1 write to 0x20.
    drive(1'b1, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    check("rst_mid_gnt1", 64'(gnt1), 64'd1);
    rst  = 1'b1;
    req1 = 1'b0;
    #1;
    check("rst_write_gated", 64'(mem_write), 64'd0);
    @(posedge clk); #1;
    check("rst_mid_flags", {56'd0, gnt0, gnt1, done0, done1, err0, err1, mem_read, mem_write}, 64'd0);
    check("rst_mid_rdata", {rdata1, rdata0}, 64'd0);
    check("rst_mid_mem_bus", {mem_addr, mem_wdata}, 64'd0);
    check("rst_mid_mem_0x20", 64'(mem_word(7'h20)), 64'h11223344);
    hold0 = '0;
    hold1 = '0;
    rst   = 1'b0;

    both_req(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF,
                   1'b0, 32'h7C, 32'h0, 32'h7F7E7D7C, "post_rst");

    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
